// File: rtl/stark_imul_wb_queue_pkg.sv
// Shared tag types for the integer-multiplier writeback queue.
package stark_imul_wb_queue_pkg;

  localparam int NROB_DEF = 32;

  typedef logic [8:0]                  pregno_t;
  typedef logic [5:0]                  aregno_t;
  typedef logic [NROB_DEF-1:0]         rob_bitmask_t;
  typedef logic [$clog2(NROB_DEF)-1:0] rob_ndx_t;

endpackage

// File: rtl/stark_imul_wbq_credit.sv
// Issue credit for the non-stallable multiplier: counts issues still in the
// pipe and grants a new issue only if a queue slot is guaranteed for it.
module stark_imul_wbq_credit #(
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic [CW-1:0] count,
  input  logic          pop,
  output logic          issue_ok
);

  logic [LAT-1:0] sr;
  logic [LAT-1:0] sr_next;
  logic [31:0]    inflight;
  logic [31:0]    used;
  logic [31:0]    limit;

  // An issue occupies the register from the cycle after it is accepted
  // until its result has been counted in the queue.
  always_comb begin
    sr_next    = sr << 1;
    sr_next[0] = issue;
    inflight   = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + 32'(sr[i]);
    used  = 32'(count) + inflight;
    limit = 32'(DEPTH) + 32'(pop);
  end

  assign issue_ok = ~rst & (used < limit);

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= sr_next;
  end

endmodule

// File: rtl/stark_imul_wb_queue.sv
// Multiplier result FIFO in front of a shared register-file write port.
// Optional same-cycle bypass when empty: define STARK_IMUL_WBQ_BYPASS_EN.
module stark_imul_wb_queue
  import stark_imul_wb_queue_pkg::*;
#(
  parameter int WID   = 64,
  parameter int DEPTH = 4,
  parameter int LAT   = 3,
  parameter int NROB  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NROB-1:0]            stomp,
  input  logic                       issue,
  input  logic [WID/8:0]             in_we,
  input  logic [WID-1:0]             in_data,
  input  logic [$clog2(NROB)-1:0]    in_rndx,
  input  pregno_t                    in_pRd,
  input  aregno_t                    in_aRd,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [WID-1:0]             wb_data,
  output logic [WID/8:0]             wb_we,
  output logic [$clog2(NROB)-1:0]    wb_rndx,
  output pregno_t                    wb_pRd,
  output aregno_t                    wb_aRd,
  output logic                       issue_ok,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int RW  = $clog2(NROB);
  localparam int WEW = WID / 8 + 1;

  typedef struct packed {
    logic           valid;
    logic           kill;
    logic [WEW-1:0] we;
    logic [WID-1:0] data;
    logic [RW-1:0]  rndx;
    pregno_t        pRd;
    aregno_t        aRd;
  } wbq_entry_t;

  wbq_entry_t    mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  wbq_entry_t head;
  logic       head_dead;
  logic       live;
  logic       pop;
  logic       push;
  logic       full;
  logic       accept;
  logic       ovf_set;

`ifdef STARK_IMUL_WBQ_BYPASS_EN
  logic byp;
  assign byp = ~rst & (count_q == '0) & (|in_we) & ~stomp[in_rndx] & wb_ready;
`endif

  // A killed head is drained on its own, one per cycle, without a write.
  always_comb begin
    head      = mem[head_ptr];
    head_dead = head.kill | stomp[head.rndx];
    live      = head.valid & ~head_dead & ~rst;
    pop       = head.valid & (head_dead | wb_ready);
    push      = |in_we;
    wb_valid  = live;
    wb_data   = live ? head.data : '0;
    wb_we     = live ? head.we   : '0;
    wb_rndx   = live ? head.rndx : '0;
    wb_pRd    = live ? head.pRd  : '0;
    wb_aRd    = live ? head.aRd  : '0;
`ifdef STARK_IMUL_WBQ_BYPASS_EN
    if (byp) begin
      push     = 1'b0;
      wb_valid = 1'b1;
      wb_data  = in_data;
      wb_we    = in_we;
      wb_rndx  = in_rndx;
      wb_pRd   = in_pRd;
      wb_aRd   = in_aRd;
    end
`endif
    full    = (count_q == CW'(DEPTH));
    accept  = push & (~full | pop);
    ovf_set = push & full & ~pop;
  end

  assign count    = rst ? '0 : count_q;
  assign overflow = overflow_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mem[i].valid & stomp[mem[i].rndx]) mem[i].kill <= 1'b1;
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + 1'b1;
      end
      // At full with a pop the tail slot is the head being freed.
      if (accept) begin
        mem[tail_ptr] <= '{valid: 1'b1, kill: stomp[in_rndx], we: in_we,
                           data: in_data, rndx: in_rndx, pRd: in_pRd, aRd: in_aRd};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      count_q <= count_q + CW'(accept) - CW'(pop);
      if (ovf_set) overflow_q <= 1'b1;
    end
  end

  stark_imul_wbq_credit #(
    .DEPTH (DEPTH),
    .LAT   (LAT),
    .CW    (CW)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .count    (count_q),
    .pop      (pop),
    .issue_ok (issue_ok)
  );

endmodule

// File: tb/tb_stark_imul_wb_queue.sv
// Directed and random checks of stark_imul_wb_queue against a queue-based model.
module tb_stark_imul_wb_queue;
  import stark_imul_wb_queue_pkg::*;

  localparam int WID   = 64;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam int NROB  = 32;
  localparam int RW    = 5;
  localparam int WEW   = 9;
  localparam int CW    = 3;

  logic            clk;
  logic            rst;
  logic [NROB-1:0] stomp;
  logic            issue;
  logic [WEW-1:0]  in_we;
  logic [WID-1:0]  in_data;
  logic [RW-1:0]   in_rndx;
  pregno_t         in_prd;
  aregno_t         in_ard;
  logic            wb_valid;
  logic            wb_ready;
  logic [WID-1:0]  wb_data;
  logic [WEW-1:0]  wb_we;
  logic [RW-1:0]   wb_rndx;
  pregno_t         wb_prd;
  aregno_t         wb_ard;
  logic            issue_ok;
  logic [CW-1:0]   count;
  logic            overflow;

  stark_imul_wb_queue #(.WID(WID), .DEPTH(DEPTH), .LAT(LAT), .NROB(NROB)) dut (
    .clk(clk), .rst(rst), .stomp(stomp), .issue(issue), .in_we(in_we),
    .in_data(in_data), .in_rndx(in_rndx), .in_pRd(in_prd), .in_aRd(in_ard),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_we(wb_we),
    .wb_rndx(wb_rndx), .wb_pRd(wb_prd), .wb_aRd(wb_ard), .issue_ok(issue_ok),
    .count(count), .overflow(overflow)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: ordered list of pending results
  typedef struct {
    logic [WEW-1:0] we;
    logic [WID-1:0] data;
    logic [RW-1:0]  rndx;
    pregno_t        prd;
    aregno_t        ard;
    bit             kill;
  } ent_t;

  ent_t          mq[$];
  bit            m_ovf;
  bit            hist[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] wr_q[$];
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_infl();
    int n = 0;
    foreach (hist[i]) n += int'(hist[i]);
    return n;
  endfunction

  function automatic bit m_pop();
    if (rst || mq.size() == 0) return 1'b0;
    return mq[0].kill || stomp[mq[0].rndx] || wb_ready;
  endfunction

  function automatic bit m_ok();
    return !rst && ((mq.size() + m_infl()) < (DEPTH + int'(m_pop())));
  endfunction

  function automatic bit m_byp();
`ifdef STARK_IMUL_WBQ_BYPASS_EN
    return !rst && mq.size() == 0 && in_we != '0 && !stomp[in_rndx] && wb_ready;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver: one clock with checks mid-cycle
  task automatic tick();
    bit   e_valid, e_pop, byp, e_ok;
    ent_t h;
    #1;
    e_pop   = m_pop();
    byp     = m_byp();
    e_ok    = m_ok();
    e_valid = 1'b0;
    h       = '{we: '0, data: '0, rndx: '0, prd: '0, ard: '0, kill: 1'b0};
    if (!rst && mq.size() > 0 && !(mq[0].kill || stomp[mq[0].rndx])) begin
      e_valid = 1'b1;
      h = mq[0];
    end
    if (byp) begin
      e_valid = 1'b1;
      h = '{we: in_we, data: in_data, rndx: in_rndx, prd: in_prd, ard: in_ard, kill: 1'b0};
    end
    chk("wb_valid", wb_valid, e_valid);
    chk("wb_data",  wb_data,  h.data);
    chk("wb_we",    wb_we,    h.we);
    chk("wb_rndx",  wb_rndx,  h.rndx);
    chk("wb_prd",   wb_prd,   h.prd);
    chk("wb_ard",   wb_ard,   h.ard);
    chk("issue_ok", issue_ok, e_ok);
    chk("count",    count,    rst ? 0 : mq.size());
    chk("overflow", overflow, rst ? 1'b0 : m_ovf);
    if (wb_valid === 1'b1 && wb_ready) wr_q.push_back(wb_rndx);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      hist.delete();
      m_ovf = 1'b0;
    end else begin
      foreach (mq[i]) if (stomp[mq[i].rndx]) mq[i].kill = 1'b1;
      if (e_pop) void'(mq.pop_front());
      if (in_we != '0 && !byp) begin
        if (mq.size() < DEPTH)
          mq.push_back('{we: in_we, data: in_data, rndx: in_rndx, prd: in_prd,
                         ard: in_ard, kill: stomp[in_rndx]});
        else
          m_ovf = 1'b1;
      end
      hist.push_back(issue);
      if (hist.size() > LAT) void'(hist.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    stomp = '0; issue = 1'b0; in_we = '0; in_data = '0;
    in_rndx = '0; in_prd = '0; in_ard = '0; wb_ready = 1'b0;
  endtask

  task automatic push_one(input logic [RW-1:0] r, input logic [WID-1:0] d);
    in_we = 9'h1FF; in_rndx = r; in_data = d;
    in_prd = pregno_t'(r + 8'd40); in_ard = aregno_t'(r + 8'd1);
    tick();
    in_we = '0;
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_n"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < wr_q.size()) chk(tag, wr_q[i], exp_q[i]);
    exp_q.delete();
    wr_q.delete();
  endtask

  // ---------------- stimulus
  initial begin
    int n_iss;
    int due[$];
    total = 0; bad = 0; m_ovf = 1'b0;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single result, ready held high
    wb_ready = 1'b1;
    push_one(5'd3, 64'h1234);
    tick(); tick();
    chk("single_count", count, 0);
    exp_q.push_back(5'd3);
    cmp_log("single_wr");

    // credit with write port blocked
    wb_ready = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 12; c++) begin
      issue = m_ok();
      if (due.size() > 0 && due[0] == c) begin
        void'(due.pop_front());
        in_we = 9'h1FF; in_data = 64'(c) * 64'h1111; in_rndx = RW'(c);
      end else in_we = '0;
      if (issue) begin n_iss++; due.push_back(c + LAT); end
      tick();
    end
    issue = 1'b0; in_we = '0;
    chk("credit_issues", n_iss, 4);
    chk("credit_count", count, 4);
    chk("credit_ovf", overflow, 1'b0);
    wb_ready = 1'b1;
    repeat (6) tick();
    wr_q.delete();

    // kill in the middle of the queue
    wb_ready = 1'b0;
    push_one(5'd5, 64'hA5);
    push_one(5'd6, 64'hA6);
    push_one(5'd7, 64'hA7);
    stomp = 32'h1 << 6;
    tick();
    stomp = '0; wb_ready = 1'b1;
    repeat (4) tick();
    exp_q.push_back(5'd5);
    exp_q.push_back(5'd7);
    cmp_log("kill_wr");

    // stomp on a live head in the same cycle as ready
    wb_ready = 1'b0;
    push_one(5'd9, 64'h99);
    stomp = 32'h1 << 9; wb_ready = 1'b1;
    tick();
    chk("stomp_head_valid_seen", wr_q.size(), 0);
    stomp = '0;
    tick();
    chk("stomp_head_count", count, 0);
    cmp_log("stomp_head_wr");

    // overflow is sticky until reset
    wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(RW'(10 + i), 64'(i + 100));
    tick(); tick();
    chk("ovf_sticky", overflow, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_issue_ok", issue_ok, 1'b1);

`ifdef STARK_IMUL_WBQ_BYPASS_EN
    wb_ready = 1'b1;
    push_one(5'd2, 64'hBEEF);
    chk("byp_count", count, 0);
    cmp_log("byp_wr");
    exp_q.delete();
`endif

    // random traffic
    wr_q.delete();
    for (int c = 0; c < 400; c++) begin
      stomp    = ($urandom_range(0, 5) == 0) ? (32'h1 << $urandom_range(0, 7)) : '0;
      in_we    = ($urandom_range(0, 1) == 1) ? WEW'($urandom_range(1, 511)) : '0;
      in_data  = {$urandom, $urandom};
      in_rndx  = RW'($urandom_range(0, 7));
      in_prd   = pregno_t'($urandom);
      in_ard   = aregno_t'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      issue    = $urandom_range(0, 1) == 1;
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    set_idle();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
